// File: rtl/syn_down_counter_nbit.sv
// Synchronous N-bit loadable down counter with terminal-count pulse and optional auto-reload.
// Define DOWN_CNT_PRESCALE_EN to add a prescaler so that only every PRESCALE-th enabled cycle acts.
module syn_down_counter_nbit #(
  parameter int N        = 4,
  parameter int PRESCALE = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         auto_reload,
  output logic [N-1:0] Q,
  output logic         tc,
  output logic         busy
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] reload_q, reload_d;
  logic         tc_q, tc_d;
  logic         tick;

  if (N < 2 || PRESCALE < 1) begin : g_bad_param
    $error("syn_down_counter_nbit: requires N >= 2 and PRESCALE >= 1");
  end

`ifdef DOWN_CNT_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;

  // The prescaler wraps on its own last count, which coincides with every
  // decrement and with every terminal event, so those clears come for free.
  always_comb begin
    ps_d = ps_q;
    tick = (ps_q == PS_LAST);
    if (load) begin
      ps_d = '0;
    end else if (state_q == COUNT && en) begin
      ps_d = tick ? '0 : ps_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ps_q <= '0;
    else       ps_q <= ps_d;
  end
`else
  always_comb tick = 1'b1;
`endif

  always_comb begin
    q_d      = q_q;
    reload_d = reload_q;
    state_d  = state_q;
    tc_d     = 1'b0;
    if (load) begin
      q_d      = load_val;
      reload_d = load_val;
      state_d  = COUNT;
    end else if (state_q == COUNT && en && tick) begin
      if (q_q == '0) begin
        tc_d = 1'b1;
        if (auto_reload) q_d     = reload_q;
        else             state_d = IDLE;
      end else begin
        q_d = q_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      state_q  <= IDLE;
    end else begin
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      state_q  <= state_d;
    end
  end

  assign Q    = q_q;
  assign tc   = tc_q;
  assign busy = (state_q == COUNT);

endmodule

// File: tb/tb_syn_down_counter_nbit.sv
// Self-checking bench for syn_down_counter_nbit: directed scenarios plus random stimulus
// checked every cycle against a cycle-level reference model.
module tb_syn_down_counter_nbit;

  localparam int N = 4;
`ifdef DOWN_CNT_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] load_val = '0;
  logic         auto_reload = 1'b0;
  logic [N-1:0] Q;
  logic         tc;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Reference model: count value, reload value, running flag, enabled-cycle phase.
  int m_q = 0;
  int m_rel = 0;
  bit m_run = 1'b0;
  bit m_tc = 1'b0;
  int m_phase = 0;

  syn_down_counter_nbit #(.N(N), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .auto_reload(auto_reload), .Q(Q), .tc(tc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    m_tc = 1'b0;
    if (reset) begin
      m_q = 0; m_rel = 0; m_run = 1'b0; m_phase = 0;
    end else if (load) begin
      m_q = int'(load_val); m_rel = int'(load_val); m_run = 1'b1; m_phase = 0;
    end else if (m_run && en) begin
      m_phase = (m_phase + 1) % PS;
      if (m_phase == 0) begin
        if (m_q == 0) begin
          m_tc = 1'b1;
          if (auto_reload) m_q = m_rel;
          else m_run = 1'b0;
        end else begin
          m_q = m_q - 1;
        end
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic cyc(input bit r, input bit e, input bit l, input int lv, input bit ar);
    reset = r; en = e; load = l; load_val = N'(lv); auto_reload = ar;
    @(posedge clk);
    model_step();
    #1;
    chk("model_Q", 32'(Q), 32'(m_q));
    chk("model_tc", 32'(tc), 32'(m_tc));
    chk("model_busy", 32'(busy), 32'(m_run));
  endtask

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 0, 0);
    chk("reset_Q", 32'(Q), 0);
    chk("reset_tc", 32'(tc), 0);
    chk("reset_busy", 32'(busy), 0);

`ifndef DOWN_CNT_PRESCALE_EN
    // One-shot from 5.
    cyc(0, 0, 1, 5, 0);
    chk("oneshot_load_Q", 32'(Q), 5);
    chk("oneshot_load_busy", 32'(busy), 1);
    for (int i = 4; i >= 0; i--) begin
      cyc(0, 1, 0, 0, 0);
      chk("oneshot_Q", 32'(Q), 32'(i));
      chk("oneshot_tc_low", 32'(tc), 0);
    end
    cyc(0, 1, 0, 0, 0);
    chk("oneshot_tc", 32'(tc), 1);
    chk("oneshot_busy", 32'(busy), 0);
    cyc(0, 1, 0, 0, 0);
    chk("oneshot_hold_Q", 32'(Q), 0);
    chk("oneshot_tc_once", 32'(tc), 0);

    // Periodic from 3: Q 2,1,0,3,... with tc on the reload cycle.
    cyc(0, 0, 1, 3, 1);
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 1, 0, 0, 1);
      chk("periodic_Q", 32'(Q), 32'((3 - (i % 4) + 4) % 4 == 3 && i % 4 == 0 ? 3 : 3 - (i % 4)));
      chk("periodic_tc", 32'(tc), 32'(i % 4 == 0));
      chk("periodic_busy", 32'(busy), 1);
    end

    // Enable gaps from 2.
    cyc(0, 0, 1, 2, 0);
    cyc(0, 1, 0, 0, 0); chk("gap_Q1", 32'(Q), 1);
    cyc(0, 0, 0, 0, 0); chk("gap_Q2", 32'(Q), 1);
    cyc(0, 0, 0, 0, 0); chk("gap_Q3", 32'(Q), 1);
    cyc(0, 1, 0, 0, 0); chk("gap_Q4", 32'(Q), 0);
    cyc(0, 1, 0, 0, 0); chk("gap_tc", 32'(tc), 1);

    // Load collides with a terminal event.
    cyc(0, 0, 1, 0, 1);
    cyc(0, 1, 1, 9, 1);
    chk("collide_Q", 32'(Q), 9);
    chk("collide_tc", 32'(tc), 0);
    chk("collide_busy", 32'(busy), 1);

    // Reset while counting at 6.
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1);
    chk("pre_reset_Q", 32'(Q), 6);
    cyc(1, 1, 0, 0, 1);
    chk("midreset_Q", 32'(Q), 0);
    chk("midreset_busy", 32'(busy), 0);
    cyc(0, 1, 0, 0, 1);
    chk("idle_en_Q", 32'(Q), 0);
    chk("idle_en_tc", 32'(tc), 0);

    // load_val = 0 with auto-reload: tc on every enabled cycle.
    cyc(0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 1);
      chk("zero_reload_tc", 32'(tc), 1);
    end
`else
    // Prescaled count from 2.
    cyc(0, 0, 1, 2, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 1, 0, 0, 0);
      if (i == 4) chk("ps_Q1", 32'(Q), 1);
      if (i == 8) chk("ps_Q0", 32'(Q), 0);
      if (i == 11) chk("ps_tc_early", 32'(tc), 0);
      if (i == 12) chk("ps_tc", 32'(tc), 1);
    end
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 11) == 0, int'($urandom_range(0, 15)),
          $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
